// File: rtl/digit_overlay_ctrl.sv
// ---------------------------------------------------------------------------
// digit_overlay_ctrl
//
// Overlay renderer for the 96x64 OLED pixel path. Draws NUM_CHARS coloured
// seven-segment digits plus a circular button-status indicator, with
// debounced buttons, a wrapping selection cursor, per-channel visibility
// toggles and an optional blinking highlight on the selected channel.
//
// Optional feature macro: OVERLAY_BLINK_EN
//   defined   : the selected channel blinks with a half-period of BLINK_HALF.
//   undefined : no blink counter; the selected channel is drawn steadily in
//               WHITE instead of its own colour.
//
// Ports (top):
//   clock_1000Hz  in   1             sole clock (1 kHz tick)
//   rst_n         in   1             asynchronous active-low reset
//   px, py        in   7 each        current pixel coordinate
//   btnL/R/C      in   1 each        raw (already synchronised) buttons
//   values        in   4*NUM_CHARS   digit value per channel
//   colours       in   16*NUM_CHARS  RGB565 colour per channel
//   oled_data     out  16            pixel colour (combinational)
//   sel           out  SEL_W         selected channel index
//   visible       out  NUM_CHARS     per-channel visibility flags
//
// Also contains the helper blocks draw_digit and draw_circle.
// ---------------------------------------------------------------------------

// draw_digit: 8x12 seven-segment glyph with its top-left at (x0_i, y0_i).
// Segments are 2 pixels thick. Values 10..15 render blank. pix_o is
// colour_i on a lit pixel, else black.
module draw_digit (
    input  logic [6:0]  px_i,
    input  logic [6:0]  py_i,
    input  logic [7:0]  x0_i,
    input  logic [7:0]  y0_i,
    input  logic [3:0]  value_i,
    input  logic [15:0] colour_i,
    output logic [15:0] pix_o
);
    logic [8:0] dx;
    logic [8:0] dy;
    logic       in_box;
    logic [2:0] lx;
    logic [3:0] ly;
    logic [6:0] seg_mask;   // {a,b,c,d,e,f,g}
    logic [6:0] seg_hit;

    assign dx     = {2'b00, px_i} - {1'b0, x0_i};
    assign dy     = {2'b00, py_i} - {1'b0, y0_i};
    assign in_box = ({1'b0, px_i} >= x0_i) && (dx < 9'd8) &&
                    ({1'b0, py_i} >= y0_i) && (dy < 9'd12);
    assign lx     = dx[2:0];
    assign ly     = dy[3:0];

    always_comb begin
        seg_mask = 7'b0000000;
        case (value_i)
            4'd0: seg_mask = 7'b1111110;
            4'd1: seg_mask = 7'b0110000;
            4'd2: seg_mask = 7'b1101101;
            4'd3: seg_mask = 7'b1111001;
            4'd4: seg_mask = 7'b0110011;
            4'd5: seg_mask = 7'b1011011;
            4'd6: seg_mask = 7'b1011111;
            4'd7: seg_mask = 7'b1110000;
            4'd8: seg_mask = 7'b1111111;
            4'd9: seg_mask = 7'b1111011;
            default: seg_mask = 7'b0000000;
        endcase
    end

    always_comb begin
        seg_hit    = 7'b0000000;
        seg_hit[6] = (ly <= 4'd1);                    // a
        seg_hit[5] = (lx >= 3'd6) && (ly <= 4'd5);    // b
        seg_hit[4] = (lx >= 3'd6) && (ly >= 4'd6);    // c
        seg_hit[3] = (ly >= 4'd10);                   // d
        seg_hit[2] = (lx <= 3'd1) && (ly >= 4'd6);    // e
        seg_hit[1] = (lx <= 3'd1) && (ly <= 4'd5);    // f
        seg_hit[0] = (ly == 4'd5) || (ly == 4'd6);    // g
    end

    assign pix_o = (in_box && |(seg_mask & seg_hit)) ? colour_i : 16'h0000;
endmodule

// draw_circle: filled disc of radius RADIUS centred on (cx_i, cy_i).
module draw_circle #(
    parameter int RADIUS = 4
) (
    input  logic [6:0]  px_i,
    input  logic [6:0]  py_i,
    input  logic [6:0]  cx_i,
    input  logic [6:0]  cy_i,
    input  logic [15:0] colour_i,
    output logic [15:0] pix_o
);
    localparam logic signed [15:0] R2 = 16'(RADIUS * RADIUS);

    logic signed [7:0]  dx;
    logic signed [7:0]  dy;
    logic signed [15:0] dxw;
    logic signed [15:0] dyw;
    logic signed [15:0] dsq;

    assign dx    = $signed({1'b0, px_i}) - $signed({1'b0, cx_i});
    assign dy    = $signed({1'b0, py_i}) - $signed({1'b0, cy_i});
    assign dxw   = {{8{dx[7]}}, dx};
    assign dyw   = {{8{dy[7]}}, dy};
    assign dsq   = dxw * dxw + dyw * dyw;
    assign pix_o = (dsq <= R2) ? colour_i : 16'h0000;
endmodule

module digit_overlay_ctrl #(
    parameter  int NUM_CHARS   = 2,
    parameter  int X0          = 18,
    parameter  int X_STEP      = 32,
    parameter  int Y0          = 8,
    parameter  int DEBOUNCE_MS = 10,
    parameter  int BLINK_HALF  = 250,
    localparam int SEL_W       = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1
) (
    input  logic                   clock_1000Hz,
    input  logic                   rst_n,
    input  logic [6:0]             px,
    input  logic [6:0]             py,
    input  logic                   btnL,
    input  logic                   btnR,
    input  logic                   btnC,
    input  logic [4*NUM_CHARS-1:0] values,
    input  logic [16*NUM_CHARS-1:0] colours,
    output logic [15:0]            oled_data,
    output logic [SEL_W-1:0]       sel,
    output logic [NUM_CHARS-1:0]   visible
);
    localparam logic [15:0] WHITE   = 16'hFFFF;
    localparam logic [15:0] MAGENTA = 16'hF87A;
    localparam int          CNT_W   = $clog2(DEBOUNCE_MS + 1);

    // ---------------- debounce: index 0 = L, 1 = R, 2 = C ----------------
    logic [2:0]       raw;
    logic [CNT_W-1:0] db_cnt_q [3];
    logic [CNT_W-1:0] db_cnt_d [3];
    logic [2:0]       stable_q, stable_d;
    logic [2:0]       stable_prev_q;
    logic [2:0]       press;

    assign raw = {btnC, btnR, btnL};

    always_comb begin
        for (int b = 0; b < 3; b++) begin
            db_cnt_d[b] = db_cnt_q[b];
            stable_d[b] = stable_q[b];
            if (raw[b] != stable_q[b]) begin
                // This clock is the DEBOUNCE_MS-th consecutive mismatch.
                if (db_cnt_q[b] == CNT_W'(DEBOUNCE_MS - 1)) begin
                    stable_d[b] = raw[b];
                    db_cnt_d[b] = '0;
                end else begin
                    db_cnt_d[b] = db_cnt_q[b] + 1'b1;
                end
            end else begin
                db_cnt_d[b] = '0;
            end
        end
    end

    // One-clock pulse in the cycle after a stable 0->1 transition.
    assign press = stable_q & ~stable_prev_q;

    // ---------------- cursor and visibility ----------------
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [NUM_CHARS-1:0] vis_q, vis_d;
    logic [15:0]          ind_q;

    always_comb begin
        sel_d = sel_q;
        if (press[0] && !press[1]) begin
            sel_d = (sel_q == '0) ? SEL_W'(NUM_CHARS - 1) : sel_q - 1'b1;
        end else if (press[1] && !press[0]) begin
            sel_d = (sel_q == SEL_W'(NUM_CHARS - 1)) ? '0 : sel_q + 1'b1;
        end
    end

    // Toggle uses the pre-move selection.
    always_comb begin
        vis_d = vis_q;
        if (press[2]) begin
            vis_d[sel_q] = ~vis_q[sel_q];
        end
    end

    always_ff @(posedge clock_1000Hz or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 3; b++) begin
                db_cnt_q[b] <= '0;
            end
            stable_q      <= '0;
            stable_prev_q <= '0;
            sel_q         <= '0;
            vis_q         <= '1;
            ind_q         <= WHITE;
        end else begin
            for (int b = 0; b < 3; b++) begin
                db_cnt_q[b] <= db_cnt_d[b];
            end
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            sel_q         <= sel_d;
            vis_q         <= vis_d;
            ind_q         <= (|stable_q) ? MAGENTA : WHITE;
        end
    end

    // ---------------- blink ----------------
    logic blink_phase;

`ifdef OVERLAY_BLINK_EN
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;

    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (sel_d != sel_q) begin
            // A moving cursor restarts in the shown phase.
            blink_cnt_d   = '0;
            blink_phase_d = 1'b1;
        end else if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end else begin
            blink_cnt_d   = blink_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock_1000Hz or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign blink_phase = blink_phase_q;
`else
    assign blink_phase = 1'b1;
`endif

    // ---------------- rendering ----------------
    logic [15:0] ch_pix [NUM_CHARS];
    logic [15:0] circle_pix;

    for (genvar i = 0; i < NUM_CHARS; i++) begin : g_ch
        localparam int XI = X0 + i * X_STEP;

        logic        is_sel;
        logic        ch_en;
        logic [15:0] ch_colour;
        logic [15:0] digit_pix;

        assign is_sel = (sel_q == SEL_W'(i));
        assign ch_en  = vis_q[i] && !(is_sel && !blink_phase);
`ifdef OVERLAY_BLINK_EN
        assign ch_colour = colours[16*i +: 16];
`else
        assign ch_colour = is_sel ? WHITE : colours[16*i +: 16];
`endif

        draw_digit u_digit (
            .px_i     (px),
            .py_i     (py),
            .x0_i     (8'(XI)),
            .y0_i     (8'(Y0)),
            .value_i  (values[4*i +: 4]),
            .colour_i (ch_colour),
            .pix_o    (digit_pix)
        );

        assign ch_pix[i] = ch_en ? digit_pix : 16'h0000;
    end

    draw_circle #(.RADIUS(4)) u_circle (
        .px_i     (px),
        .py_i     (py),
        .cx_i     (7'd7),
        .cy_i     (7'd7),
        .colour_i (ind_q),
        .pix_o    (circle_pix)
    );

    // Lowest-index non-black channel wins, then the indicator, then black.
    always_comb begin
        oled_data = circle_pix;
        for (int i = NUM_CHARS - 1; i >= 0; i--) begin
            if (ch_pix[i] != 16'h0000) begin
                oled_data = ch_pix[i];
            end
        end
    end

    assign sel     = sel_q;
    assign visible = vis_q;
endmodule

// File: tb/tb_digit_overlay_ctrl.sv
// ---------------------------------------------------------------------------
// tb_digit_overlay_ctrl
//
// Directed bench for digit_overlay_ctrl (NUM_CHARS=2, channels placed so that
// channel 0 overlaps the indicator circle). A behavioural model follows the
// button/cursor/blink rules in plain integer terms and predicts every output;
// a per-cycle check compares sel, visible and oled_data at a set of probe
// pixels. Literal expectations at key points pin the model itself.
// Works with and without OVERLAY_BLINK_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_digit_overlay_ctrl;
    localparam int NCH = 2;
    localparam int X0  = 4;
    localparam int XS  = 32;
    localparam int Y0  = 4;
    localparam int DB  = 10;
    localparam int BH  = 250;

    localparam logic [15:0] C0 = 16'h001F;
    localparam logic [15:0] C1 = 16'h07E0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #50 clk = ~clk;

    logic [6:0]       px = '0;
    logic [6:0]       py = '0;
    logic             btnL = 1'b0;
    logic             btnR = 1'b0;
    logic             btnC = 1'b0;
    logic [4*NCH-1:0] values = 8'h99;
    logic [16*NCH-1:0] colours = {C1, C0};
    logic [15:0]      oled_data;
    logic [0:0]       sel;
    logic [NCH-1:0]   visible;

    digit_overlay_ctrl #(
        .NUM_CHARS   (NCH),
        .X0          (X0),
        .X_STEP      (XS),
        .Y0          (Y0),
        .DEBOUNCE_MS (DB),
        .BLINK_HALF  (BH)
    ) dut (
        .clock_1000Hz (clk),
        .rst_n        (rst_n),
        .px           (px),
        .py           (py),
        .btnL         (btnL),
        .btnR         (btnR),
        .btnC         (btnC),
        .values       (values),
        .colours      (colours),
        .oled_data    (oled_data),
        .sel          (sel),
        .visible      (visible)
    );

    // ---------------- behavioural model ----------------
    wire [2:0] raw_btn = {btnC, btnR, btnL};

    int             m_sel;
    logic [NCH-1:0] m_vis;
    int             m_age;       // clocks since the last blink restart
    logic           m_ind;       // 1 = magenta
    logic [2:0]     m_stable;
    logic [2:0]     m_last;
    int             m_streak [3];
    logic [2:0]     m_pend;      // press events consumed on the next clock

    string seg_tab [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                            "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

    function automatic int sel_after(input int s, input logic [2:0] ev);
        if (ev[0] && !ev[1]) return (s == 0) ? NCH - 1 : s - 1;
        if (ev[1] && !ev[0]) return (s + 1) % NCH;
        return s;
    endfunction

    function automatic int streak_after(input logic r, input logic last, input int s);
        return (r == last) ? s + 1 : 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sel    <= 0;
            m_vis    <= '1;
            m_age    <= 0;
            m_ind    <= 1'b0;
            m_stable <= '0;
            m_last   <= '0;
            m_pend   <= '0;
            for (int b = 0; b < 3; b++) m_streak[b] <= 0;
        end else begin
            m_sel <= sel_after(m_sel, m_pend);
            m_vis <= m_pend[2] ? (m_vis ^ (NCH'(1) << m_sel)) : m_vis;
            m_age <= (sel_after(m_sel, m_pend) != m_sel) ? 0 : m_age + 1;
            m_ind <= |m_stable;
            m_last <= raw_btn;
            for (int b = 0; b < 3; b++) begin
                m_streak[b] <= streak_after(raw_btn[b], m_last[b], m_streak[b]);
                if (raw_btn[b] != m_stable[b] &&
                    streak_after(raw_btn[b], m_last[b], m_streak[b]) >= DB) begin
                    m_stable[b] <= raw_btn[b];
                    m_pend[b]   <= raw_btn[b];
                end else begin
                    m_pend[b]   <= 1'b0;
                end
            end
        end
    end

    function automatic bit digit_lit(input int v, input int lx, input int ly);
        string s;
        if (v > 9) return 0;
        s = seg_tab[v];
        for (int k = 0; k < s.len(); k++) begin
            case (s[k])
                "a": if (ly <= 1) return 1;
                "b": if (lx >= 6 && ly <= 5) return 1;
                "c": if (lx >= 6 && ly >= 6) return 1;
                "d": if (ly >= 10) return 1;
                "e": if (lx <= 1 && ly >= 6) return 1;
                "f": if (lx <= 1 && ly <= 5) return 1;
                "g": if (ly == 5 || ly == 6) return 1;
                default: ;
            endcase
        end
        return 0;
    endfunction

    function automatic logic [15:0] exp_pixel(input int x, input int y);
        bit          shown_phase;
        int          ox;
        int          v;
        logic [15:0] col;
`ifdef OVERLAY_BLINK_EN
        shown_phase = ((m_age / BH) % 2) == 0;
`else
        shown_phase = 1;
`endif
        for (int i = 0; i < NCH; i++) begin
            ox = X0 + i * XS;
            v  = int'(values[4*i +: 4]);
            if (m_vis[i] && !(i == m_sel && !shown_phase) &&
                x >= ox && x < ox + 8 && y >= Y0 && y < Y0 + 12 &&
                digit_lit(v, x - ox, y - Y0)) begin
`ifdef OVERLAY_BLINK_EN
                col = colours[16*i +: 16];
`else
                col = (i == m_sel) ? 16'hFFFF : colours[16*i +: 16];
`endif
                if (col != 16'h0000) return col;
            end
        end
        if ((x - 7) * (x - 7) + (y - 7) * (y - 7) <= 16)
            return m_ind ? 16'hF87A : 16'hFFFF;
        return 16'h0000;
    endfunction

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    int probe_x [6] = '{7, 7, 4, 39, 39, 10};
    int probe_y [6] = '{7, 5, 4, 5, 9, 14};

    task automatic check_cycle();
        int x;
        int y;
        chk("sel", 32'(sel), 32'(m_sel));
        chk("visible", 32'(visible), 32'(m_vis));
        for (int k = 0; k < 7; k++) begin
            if (k < 6) begin
                x = probe_x[k];
                y = probe_y[k];
            end else begin
                x = int'($urandom_range(0, 95));
                y = int'($urandom_range(0, 63));
            end
            px = 7'(x);
            py = 7'(y);
            #1;
            chk("pixel", 32'(oled_data), 32'(exp_pixel(x, y)));
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            check_cycle();
        end
    endtask

    task automatic lit_pix(input string name, input int x, input int y, input logic [15:0] exp);
        px = 7'(x);
        py = 7'(y);
        #1;
        chk(name, 32'(oled_data), 32'(exp));
    endtask

    task automatic press(input logic l, input logic r, input logic c);
        btnL = l;
        btnR = r;
        btnC = c;
        tick(DB + 1);
        btnL = 1'b0;
        btnR = 1'b0;
        btnC = 1'b0;
        tick(DB + 2);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        tick(3);
        rst_n = 1'b1;
        tick(1);
        chk("reset_sel", 32'(sel), 32'd0);
        chk("reset_vis", 32'(visible), 32'h3);
        lit_pix("reset_circle", 7, 7, 16'hFFFF);
        lit_pix("reset_ch1", 39, 5, C1);
`ifdef OVERLAY_BLINK_EN
        lit_pix("reset_ch0", 7, 5, C0);
`else
        lit_pix("reset_ch0", 7, 5, 16'hFFFF);
`endif

        // R held: stable after DB clocks, cursor moves on the next edge.
        btnR = 1'b1;
        tick(DB);
        chk("r_not_yet", 32'(sel), 32'd0);
        tick(1);
        chk("r_moved", 32'(sel), 32'd1);
        lit_pix("ind_magenta", 7, 7, 16'hF87A);
        btnR = 1'b0;
        tick(DB + 2);
        lit_pix("ind_white", 7, 7, 16'hFFFF);

        // Short glitch is ignored.
        btnR = 1'b1;
        tick(5);
        btnR = 1'b0;
        tick(DB + 2);
        chk("glitch_sel", 32'(sel), 32'd1);

        press(1'b1, 1'b0, 1'b0);
        chk("l_dec", 32'(sel), 32'd0);
        press(1'b1, 1'b0, 1'b0);
        chk("l_wrap", 32'(sel), 32'd1);
        press(1'b1, 1'b1, 1'b0);
        chk("lr_hold", 32'(sel), 32'd1);

        press(1'b0, 1'b0, 1'b1);
        chk("c_hide", 32'(visible), 32'h1);
        lit_pix("c_hidden_px", 39, 5, 16'h0000);
        press(1'b0, 1'b0, 1'b1);
        chk("c_show", 32'(visible), 32'h3);

        // Blink: R wraps to channel 0, then wait into the off half-period.
        press(1'b0, 1'b1, 1'b0);
        chk("r_wrap", 32'(sel), 32'd0);
        tick(BH);
`ifdef OVERLAY_BLINK_EN
        lit_pix("blink_off", 4, 4, 16'h0000);
`else
        lit_pix("steady_sel", 4, 4, 16'hFFFF);
`endif
        btnL = 1'b1;
        tick(DB + 1);
        chk("move_in_off", 32'(sel), 32'd1);
        lit_pix("old_sel_back", 4, 4, C0);
`ifdef OVERLAY_BLINK_EN
        lit_pix("new_sel_shown", 39, 5, C1);
`else
        lit_pix("new_sel_shown", 39, 5, 16'hFFFF);
`endif
        btnL = 1'b0;
        tick(DB + 2);
        tick(2 * BH + 20);

        // Out-of-range value renders blank; channel beats circle on overlap.
        values = 8'h9C;
        tick(2);
        lit_pix("blank_ch0", 4, 4, 16'h0000);
        lit_pix("blank_circle", 7, 5, 16'hFFFF);
        values = 8'h99;
        tick(2);
        lit_pix("overlap_ch_wins", 7, 5, C0);

        // Asynchronous reset in the middle of a debounce run.
        btnC = 1'b1;
        tick(5);
        #10;
        rst_n = 1'b0;
        #1;
        chk("async_sel", 32'(sel), 32'd0);
        chk("async_vis", 32'(visible), 32'h3);
        lit_pix("async_circle", 7, 7, 16'hFFFF);
        tick(2);
        rst_n = 1'b1;
        tick(DB);
        chk("post_rst_vis", 32'(visible), 32'h3);
        tick(1);
        chk("post_rst_toggle", 32'(visible), 32'h2);
        btnC = 1'b0;
        tick(DB + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
